// File: rtl/interrupt_vector_ctrl.sv
// Interrupt/reset sequencer: synchronises NMI/IRQ, arbitrates RES > NMI > IRQ,
// injects BRK at opcode fetch and drives the ADL vector-forcing controls.
module interrupt_vector_ctrl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       phi2,
    input  logic       rst_n,
    input  logic       NMI_n,
    input  logic       IRQ_n,
    input  logic       I_flag,
    input  logic       fetch,
    input  logic       brk_op,
    input  logic       vec_lo,
    input  logic       vec_hi,
    output logic       force_brk,
    output logic       O_ADL0,
    output logic       O_ADL1,
    output logic       O_ADL2,
    output logic       B_bit,
    output logic       set_I,
    output logic       wr_inhibit,
    output logic [1:0] int_type
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEQ  = 2'd1;
    localparam logic [1:0] ST_VLO  = 2'd2;
    localparam logic [1:0] ST_VHI  = 2'd3;

    localparam logic [1:0] INT_NONE = 2'b00;
    localparam logic [1:0] INT_IRQ  = 2'b01;
    localparam logic [1:0] INT_NMI  = 2'b10;
    localparam logic [1:0] INT_RES  = 2'b11;

    logic [SYNC_STAGES-1:0] nmi_sync_reg;
    logic [SYNC_STAGES-1:0] irq_sync_reg;
    logic                   nmi_s;
    logic                   irq_s;
    logic                   nmi_prev_reg;
    logic                   nmi_edge;

    logic [1:0] state_reg, state_next;
    logic [1:0] int_type_reg, int_type_next;
    logic       hw_int_reg, hw_int_next;
    logic       nmi_pend_reg, nmi_pend_next;
    logic       res_pend_reg, res_pend_next;
    logic [1:0] winner;
    logic       force_brk_c;

    // Synchroniser chains idle high so a reset never looks like a pin edge.
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge phi2) begin
                    if (!rst_n) begin
                        nmi_sync_reg[gi] <= 1'b1;
                        irq_sync_reg[gi] <= 1'b1;
                    end else begin
                        nmi_sync_reg[gi] <= NMI_n;
                        irq_sync_reg[gi] <= IRQ_n;
                    end
                end
            end else begin : g_rest
                always_ff @(posedge phi2) begin
                    if (!rst_n) begin
                        nmi_sync_reg[gi] <= 1'b1;
                        irq_sync_reg[gi] <= 1'b1;
                    end else begin
                        nmi_sync_reg[gi] <= nmi_sync_reg[gi-1];
                        irq_sync_reg[gi] <= irq_sync_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign nmi_s    = nmi_sync_reg[SYNC_STAGES-1];
    assign irq_s    = irq_sync_reg[SYNC_STAGES-1];
    assign nmi_edge = nmi_prev_reg & ~nmi_s;

    always_comb begin
        winner = INT_NONE;
        if (res_pend_reg)
            winner = INT_RES;
        else if (nmi_pend_reg)
            winner = INT_NMI;
        else if (~irq_s & ~I_flag)
            winner = INT_IRQ;
    end

    always_comb begin
        state_next    = state_reg;
        int_type_next = int_type_reg;
        hw_int_next   = hw_int_reg;
        nmi_pend_next = nmi_pend_reg | nmi_edge;
        res_pend_next = res_pend_reg;
        force_brk_c   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (fetch && (winner != INT_NONE)) begin
                    force_brk_c   = 1'b1;
                    state_next    = ST_SEQ;
                    int_type_next = winner;
                    hw_int_next   = 1'b1;
                end else if (brk_op) begin
                    state_next    = ST_SEQ;
                    int_type_next = INT_IRQ;
                    hw_int_next   = 1'b0;
                end
            end
            ST_SEQ: begin
                // The vector choice freezes once vec_lo is seen, so a late NMI
                // can only hijack an IRQ/BRK up to the cycle before it.
                if (vec_lo)
                    state_next = ST_VLO;
                else if ((int_type_reg == INT_IRQ) && nmi_pend_reg)
                    int_type_next = INT_NMI;
            end
            ST_VLO: begin
                if (vec_hi)
                    state_next = ST_VHI;
            end
            default: begin
                state_next    = ST_IDLE;
                int_type_next = INT_NONE;
                hw_int_next   = 1'b0;
                if ((int_type_reg == INT_NMI) && !nmi_edge)
                    nmi_pend_next = 1'b0;
                if (int_type_reg == INT_RES)
                    res_pend_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge phi2) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            int_type_reg <= INT_NONE;
            hw_int_reg   <= 1'b0;
            nmi_pend_reg <= 1'b0;
            res_pend_reg <= 1'b1;
            nmi_prev_reg <= 1'b1;
        end else begin
            state_reg    <= state_next;
            int_type_reg <= int_type_next;
            hw_int_reg   <= hw_int_next;
            nmi_pend_reg <= nmi_pend_next;
            res_pend_reg <= res_pend_next;
            nmi_prev_reg <= nmi_s;
        end
    end

    // Outputs are forced to their idle values whenever rst_n is low.
    always_comb begin
        force_brk  = 1'b0;
        O_ADL0     = 1'b1;
        O_ADL1     = 1'b1;
        O_ADL2     = 1'b1;
        B_bit      = 1'b1;
        set_I      = 1'b0;
        wr_inhibit = 1'b0;
        int_type   = INT_NONE;
        if (rst_n) begin
            force_brk  = force_brk_c;
            O_ADL0     = ~(state_reg == ST_VLO);
            O_ADL1     = ~(((state_reg == ST_VLO) || (state_reg == ST_VHI)) &&
                           (int_type_reg == INT_RES));
            O_ADL2     = ~(((state_reg == ST_VLO) || (state_reg == ST_VHI)) &&
                           (int_type_reg == INT_NMI));
            B_bit      = ~((state_reg == ST_SEQ) && hw_int_reg);
            set_I      = (state_reg == ST_VHI);
            wr_inhibit = ((state_reg == ST_SEQ) || (state_reg == ST_VLO)) &&
                         (int_type_reg == INT_RES);
            int_type   = int_type_reg;
        end
    end

endmodule

// File: tb/tb_interrupt_vector_ctrl.sv
// Directed bench for interrupt_vector_ctrl: reset, RES/NMI/IRQ/BRK sequences,
// NMI hijack, simultaneous pending events and mid-sequence reset.
module tb_interrupt_vector_ctrl;

    logic       phi2 = 1'b0;
    logic       rst_n, NMI_n, IRQ_n, I_flag, fetch, brk_op, vec_lo, vec_hi;
    logic       force_brk, O_ADL0, O_ADL1, O_ADL2, B_bit, set_I, wr_inhibit;
    logic [1:0] int_type;
    int         checks = 0;
    int         errors = 0;
    int         brk_count;

    interrupt_vector_ctrl #(.SYNC_STAGES(2)) dut (
        .phi2(phi2), .rst_n(rst_n), .NMI_n(NMI_n), .IRQ_n(IRQ_n),
        .I_flag(I_flag), .fetch(fetch), .brk_op(brk_op),
        .vec_lo(vec_lo), .vec_hi(vec_hi), .force_brk(force_brk),
        .O_ADL0(O_ADL0), .O_ADL1(O_ADL1), .O_ADL2(O_ADL2), .B_bit(B_bit),
        .set_I(set_I), .wr_inhibit(wr_inhibit), .int_type(int_type)
    );

    always #5 phi2 = ~phi2;

    function automatic logic [7:0] adl();
        return {5'b11111, O_ADL2, O_ADL1, O_ADL0};
    endfunction

    task automatic tick();
        @(posedge phi2);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-14s observed %0h expected %0h", tag, obs, exp);
    endtask

    // Runs vec_lo/vec_hi of an open sequence, checking both vector bytes.
    task automatic run_vectors(input string tag, input logic [7:0] lo, input logic [7:0] hi);
        vec_lo = 1'b1;
        tick();
        vec_lo = 1'b0;
        settle();
        chk({tag, "_lo"}, adl(), lo);
        vec_hi = 1'b1;
        tick();
        vec_hi = 1'b0;
        settle();
        chk({tag, "_hi"}, adl(), hi);
        chk({tag, "_setI"}, {7'd0, set_I}, 8'd1);
        tick();
        settle();
        chk({tag, "_done"}, {6'd0, int_type}, 8'd0);
    endtask

    initial begin
        rst_n = 1'b0; NMI_n = 1'b1; IRQ_n = 1'b1; I_flag = 1'b1;
        fetch = 1'b0; brk_op = 1'b0; vec_lo = 1'b0; vec_hi = 1'b0;

        // Reset state, including a fetch while held in reset
        repeat (3) tick();
        fetch = 1'b1;
        settle();
        chk("rst_force", {7'd0, force_brk}, 8'd0);
        chk("rst_adl", adl(), 8'hFF);
        chk("rst_B", {7'd0, B_bit}, 8'd1);
        chk("rst_setI", {7'd0, set_I}, 8'd0);
        chk("rst_wrinh", {7'd0, wr_inhibit}, 8'd0);
        chk("rst_type", {6'd0, int_type}, 8'd0);
        fetch = 1'b0;

        // RES sequence after release
        rst_n = 1'b1;
        tick();
        fetch = 1'b1;
        settle();
        chk("res_force", {7'd0, force_brk}, 8'd1);
        tick();
        fetch = 1'b0;
        settle();
        chk("res_type", {6'd0, int_type}, 8'd3);
        chk("res_wrinh", {7'd0, wr_inhibit}, 8'd1);
        chk("res_B", {7'd0, B_bit}, 8'd0);
        vec_lo = 1'b1;
        tick();
        vec_lo = 1'b0;
        settle();
        chk("res_lo", adl(), 8'hFC);
        chk("res_wrinh_vlo", {7'd0, wr_inhibit}, 8'd1);
        vec_hi = 1'b1;
        tick();
        vec_hi = 1'b0;
        settle();
        chk("res_hi", adl(), 8'hFD);
        chk("res_setI", {7'd0, set_I}, 8'd1);
        tick();
        fetch = 1'b1;
        settle();
        chk("res_cleared", {7'd0, force_brk}, 8'd0);
        chk("res_setI_off", {7'd0, set_I}, 8'd0);
        fetch = 1'b0;

        // Stray vec_lo in IDLE is ignored
        vec_lo = 1'b1;
        tick();
        vec_lo = 1'b0;
        settle();
        chk("stray_vlo", adl(), 8'hFF);

        // NMI: pin low at edge k sets pending at edge k+2
        NMI_n = 1'b0;
        tick();
        tick();
        fetch = 1'b1;
        settle();
        chk("nmi_early", {7'd0, force_brk}, 8'd0);
        tick();
        settle();
        chk("nmi_force", {7'd0, force_brk}, 8'd1);
        tick();
        fetch = 1'b0;
        settle();
        chk("nmi_type", {6'd0, int_type}, 8'd2);
        chk("nmi_B", {7'd0, B_bit}, 8'd0);
        run_vectors("nmi", 8'hFA, 8'hFB);

        // Held-low NMI gives no second sequence
        brk_count = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            fetch = 1'b1;
            settle();
            if (force_brk) brk_count++;
        end
        chk("nmi_held", brk_count[7:0], 8'd0);
        fetch = 1'b0;
        NMI_n = 1'b1;
        repeat (3) tick();

        // IRQ unmasked
        IRQ_n = 1'b0; I_flag = 1'b0;
        repeat (3) tick();
        fetch = 1'b1;
        settle();
        chk("irq_force", {7'd0, force_brk}, 8'd1);
        tick();
        fetch = 1'b0;
        IRQ_n = 1'b1;
        settle();
        chk("irq_type", {6'd0, int_type}, 8'd1);
        chk("irq_B", {7'd0, B_bit}, 8'd0);
        run_vectors("irq", 8'hFE, 8'hFF);

        // IRQ masked
        I_flag = 1'b1; IRQ_n = 1'b0;
        repeat (3) tick();
        fetch = 1'b1;
        settle();
        chk("irq_masked", {7'd0, force_brk}, 8'd0);
        tick();
        fetch = 1'b0;
        IRQ_n = 1'b1;

        // IRQ withdrawn before fetch is not taken
        I_flag = 1'b0; IRQ_n = 1'b0;
        repeat (3) tick();
        IRQ_n = 1'b1;
        repeat (3) tick();
        fetch = 1'b1;
        settle();
        chk("irq_withdrawn", {7'd0, force_brk}, 8'd0);
        fetch = 1'b0;
        I_flag = 1'b1;

        // Software BRK hijacked by NMI
        brk_op = 1'b1;
        tick();
        brk_op = 1'b0;
        settle();
        chk("brk_type", {6'd0, int_type}, 8'd1);
        chk("brk_B", {7'd0, B_bit}, 8'd1);
        NMI_n = 1'b0;
        repeat (4) tick();
        settle();
        chk("hijack_type", {6'd0, int_type}, 8'd2);
        chk("hijack_B", {7'd0, B_bit}, 8'd1);
        run_vectors("hijack", 8'hFA, 8'hFB);
        fetch = 1'b1;
        settle();
        chk("hijack_clr", {7'd0, force_brk}, 8'd0);
        fetch = 1'b0;
        NMI_n = 1'b1;
        repeat (3) tick();

        // NMI edge landing in VHI of an NMI sequence stays pending
        NMI_n = 1'b0;
        repeat (3) tick();
        NMI_n = 1'b1;
        fetch = 1'b1;
        tick();
        fetch = 1'b0;
        NMI_n = 1'b0;
        vec_lo = 1'b1;
        tick();
        vec_lo = 1'b0;
        vec_hi = 1'b1;
        settle();
        chk("vhi_edge_lo", adl(), 8'hFA);
        tick();
        vec_hi = 1'b0;
        settle();
        chk("vhi_edge_hi", adl(), 8'hFB);
        tick();
        fetch = 1'b1;
        settle();
        chk("vhi_edge_kept", {7'd0, force_brk}, 8'd1);
        tick();
        fetch = 1'b0;
        settle();
        chk("vhi_edge_type", {6'd0, int_type}, 8'd2);
        run_vectors("vhi_edge2", 8'hFA, 8'hFB);
        NMI_n = 1'b1;
        repeat (3) tick();

        // RES, NMI and IRQ all pending at one fetch
        rst_n = 1'b0; NMI_n = 1'b0; IRQ_n = 1'b0; I_flag = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        fetch = 1'b1;
        settle();
        chk("all_force1", {7'd0, force_brk}, 8'd1);
        tick();
        fetch = 1'b0;
        settle();
        chk("all_res", {6'd0, int_type}, 8'd3);
        run_vectors("all_res", 8'hFC, 8'hFD);
        fetch = 1'b1;
        settle();
        chk("all_force2", {7'd0, force_brk}, 8'd1);
        tick();
        fetch = 1'b0;
        settle();
        chk("all_nmi", {6'd0, int_type}, 8'd2);
        run_vectors("all_nmi", 8'hFA, 8'hFB);
        fetch = 1'b1;
        settle();
        chk("all_force3", {7'd0, force_brk}, 8'd1);
        tick();
        fetch = 1'b0;
        settle();
        chk("all_irq", {6'd0, int_type}, 8'd1);
        run_vectors("all_irq", 8'hFE, 8'hFF);
        IRQ_n = 1'b1; NMI_n = 1'b1; I_flag = 1'b1;
        repeat (3) tick();

        // Reset during VLO of an NMI sequence
        NMI_n = 1'b0;
        repeat (3) tick();
        fetch = 1'b1;
        tick();
        fetch = 1'b0;
        vec_lo = 1'b1;
        tick();
        vec_lo = 1'b0;
        settle();
        chk("abort_vlo", adl(), 8'hFA);
        rst_n = 1'b0;
        NMI_n = 1'b1;
        tick();
        settle();
        chk("abort_adl", adl(), 8'hFF);
        chk("abort_type", {6'd0, int_type}, 8'd0);
        chk("abort_B", {7'd0, B_bit}, 8'd1);
        chk("abort_setI", {7'd0, set_I}, 8'd0);
        rst_n = 1'b1;
        tick();
        fetch = 1'b1;
        settle();
        chk("abort_force", {7'd0, force_brk}, 8'd1);
        tick();
        fetch = 1'b0;
        settle();
        chk("abort_res", {6'd0, int_type}, 8'd3);
        run_vectors("abort_res", 8'hFC, 8'hFD);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
